// File: rtl/vga_pkg.sv
// Shared definitions for the VGA sink: default 640x480@60 raster timing, receiver FSM states, pixel type.
package vga_pkg;

    localparam int VGA_H_ACTIVE    = 640;
    localparam int VGA_H_FP        = 16;
    localparam int VGA_H_SYNC      = 96;
    localparam int VGA_H_BP        = 48;
    localparam int VGA_V_ACTIVE    = 480;
    localparam int VGA_V_FP        = 10;
    localparam int VGA_V_SYNC      = 2;
    localparam int VGA_V_BP        = 33;
    localparam int VGA_LOCK_FRAMES = 2;

    localparam int VGA_HT       = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_VT       = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
    localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        LOCKED
    } rx_state_t;

    typedef logic [11:0] rgb12_t;

endpackage

// File: rtl/vga_rx_crc16.sv
// CRC-16-CCITT (poly 0x1021) step folding one 12-bit pixel per cycle, MSB first.
// init restarts from 0xFFFF; when en is also high the pixel is folded into the fresh seed.
module vga_rx_crc16
    import vga_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic        en_i,
    input  rgb12_t      data_i,
    output logic [15:0] crc_next_o
);

    logic [15:0] crc_q;
    logic [15:0] base;
    logic [15:0] step;

    always_comb begin
        base = init_i ? 16'hFFFF : crc_q;
        step = base;
        for (int i = 11; i >= 0; i--) begin
            if (step[15] ^ data_i[i]) begin
                step = {step[14:0], 1'b0} ^ 16'h1021;
            end else begin
                step = {step[14:0], 1'b0};
            end
        end
        crc_next_o = en_i ? step : base;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_next_o;
        end
    end

endmodule

// File: rtl/vga_timing_rx.sv
// VGA sink: recovers x/y/de from active-low syncs, checks the raster and reports lock.
// Defining VGA_RX_CRC_EN adds a per-frame CRC-16 of the active picture (crc16/crc_valid ports).
module vga_timing_rx
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic        vgaclk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic [11:0] rgb_o,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err
`ifdef VGA_RX_CRC_EN
    ,
    output logic [15:0] crc16,
    output logic        crc_valid
`endif
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [7:0] LOCK_N   = 8'(LOCK_FRAMES);

    logic       hs1_q, vs1_q, hs_prev_q, vs_prev_q;
    rgb12_t     rgb1_q;
    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [9:0] hcur, vcur;
    logic [7:0] good_q, good_d;
    rx_state_t  state_q, state_d;

    logic hs_fall, vs_fall, exp_hs, exp_vs, mismatch, frame_wrap;
    logic locked_d, de_d, fs_d, sync_err_d;

    logic [9:0] x_q, y_q;
    logic       de_q, fs_q, locked_q, sync_err_q;
    rgb12_t     rgb_q;

    // hcur/vcur are the coordinates of the pixel now in stage 1, including any
    // reload taken this cycle, so outputs and checks refer to that same pixel.
    always_comb begin
        hs_fall    = !hs1_q && hs_prev_q;
        vs_fall    = !vs1_q && vs_prev_q;
        hcur       = hcnt_q;
        vcur       = vcnt_q;
        good_d     = good_q;
        state_d    = state_q;
        sync_err_d = 1'b0;

        if (state_q == SEARCH) begin
            if (vs_fall) begin
                hcur    = '0;
                vcur    = VS_FIRST;
                good_d  = '0;
                state_d = ALIGN;
            end else if (hs_fall) begin
                hcur = HS_FIRST;
            end
        end

        exp_hs     = !((hcur >= HS_FIRST) && (hcur <= HS_LAST));
        exp_vs     = !((vcur >= VS_FIRST) && (vcur <= VS_LAST));
        mismatch   = (state_q != SEARCH) && ((hs1_q != exp_hs) || (vs1_q != exp_vs));
        frame_wrap = (hcur == H_LAST) && (vcur == V_LAST);

        if (mismatch) begin
            sync_err_d = 1'b1;
            good_d     = '0;
            state_d    = SEARCH;
        end else if ((state_q == ALIGN) && frame_wrap) begin
            good_d = good_q + 8'd1;
            if (good_d == LOCK_N) begin
                state_d = LOCKED;
            end
        end

        hcnt_d = (hcur == H_LAST) ? '0 : hcur + 10'd1;
        vcnt_d = vcur;
        if (hcur == H_LAST) begin
            vcnt_d = (vcur == V_LAST) ? '0 : vcur + 10'd1;
        end

        // Lock follows the next state so a mismatch drops it on its own output cycle.
        locked_d = (state_d == LOCKED);
        de_d     = locked_d && (hcur < H_ACT) && (vcur < V_ACT);
        fs_d     = locked_d && (hcur == '0) && (vcur == '0);
    end

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            hs_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            rgb1_q     <= '0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            good_q     <= '0;
            state_q    <= SEARCH;
            x_q        <= '0;
            y_q        <= '0;
            de_q       <= 1'b0;
            rgb_q      <= '0;
            fs_q       <= 1'b0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            hs1_q      <= hsync;
            vs1_q      <= vsync;
            hs_prev_q  <= hs1_q;
            vs_prev_q  <= vs1_q;
            rgb1_q     <= {red, green, blue};
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            good_q     <= good_d;
            state_q    <= state_d;
            x_q        <= hcur;
            y_q        <= vcur;
            de_q       <= de_d;
            rgb_q      <= de_d ? rgb1_q : '0;
            fs_q       <= fs_d;
            locked_q   <= locked_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_q;
    assign rgb_o       = rgb_q;
    assign frame_start = fs_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

`ifdef VGA_RX_CRC_EN
    localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);

    logic [15:0] crc_next, crc16_q;
    logic        crc_valid_q, frame_ok_q, last_px;

    vga_rx_crc16 u_crc (
        .clk_i      (vgaclk),
        .rst_i      (rst),
        .init_i     (fs_q || sync_err_q),
        .en_i       (de_q),
        .data_i     (rgb_q),
        .crc_next_o (crc_next)
    );

    assign last_px = de_q && (x_q == H_ACT_LAST) && (y_q == V_ACT_LAST);

    // A frame only publishes its CRC if it started clean and saw no sync error.
    always_ff @(posedge vgaclk) begin
        if (rst) begin
            crc16_q     <= '0;
            crc_valid_q <= 1'b0;
            frame_ok_q  <= 1'b0;
        end else begin
            crc_valid_q <= last_px && frame_ok_q;
            if (last_px && frame_ok_q) begin
                crc16_q <= crc_next;
            end
            if (sync_err_q) begin
                frame_ok_q <= 1'b0;
            end else if (fs_q) begin
                frame_ok_q <= 1'b1;
            end
        end
    end

    assign crc16     = crc16_q;
    assign crc_valid = crc_valid_q;
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx on a reduced 25x13 raster; frame-CRC checks are added
// when VGA_RX_CRC_EN is defined.
`timescale 1ns/1ps
module tb_vga_timing_rx;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 8, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int HS0 = HA + HF, HS1 = HS0 + HS - 1;
    localparam int VT = VA + VF + VS + VB;
    localparam int VS0 = VA + VF, VS1 = VS0 + VS - 1;
    localparam int NF = 20;
    localparam int SHOW_LIMIT = 3000;

    logic        vgaclk = 1'b0;
    logic        rst, hsync, vsync;
    logic [3:0]  red, green, blue;
    logic [9:0]  x, y;
    logic        de, frame_start, locked, sync_err;
    logic [11:0] rgb_o;
`ifdef VGA_RX_CRC_EN
    logic [15:0] crc16;
    logic        crc_valid;
`endif

    int checks = 0;
    int errors = 0;

    // generator position, pixel driven last call, pixel the outputs now describe
    int gen_f = 0, gen_h = 0, gen_v = 0;
    int drv_f = 0, drv_h = 0, drv_v = 0;
    int out_f = 0, out_h = 0, out_v = 0;

    int          ovr_f = 3, ovr_h = 5, ovr_v = 7;
    logic [11:0] ovr_rgb = 12'h0F0;
    int          drop_f = 4, drop_v = 3;
    int          rst_f = 6, rst_h = 10, rst_v = 4;
    int          short_first = 8, short_last = 10;

    int          de_f[NF];
    int          se_f[NF];
    int          lk_f[NF];
    int          cv_f[NF];
    logic [15:0] crc_f[NF];
    int          bad_rgb = 0;
    logic [11:0] exp_q[$];

    vga_timing_rx #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .LOCK_FRAMES(2)
    ) dut (
        .vgaclk      (vgaclk),
        .rst         (rst),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .x           (x),
        .y           (y),
        .de          (de),
        .rgb_o       (rgb_o),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err)
`ifdef VGA_RX_CRC_EN
        ,
        .crc16       (crc16),
        .crc_valid   (crc_valid)
`endif
    );

    // clock
    always #5 vgaclk = ~vgaclk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one raster pixel, then books the outputs, which describe the previous pixel.
    task automatic drive_px();
        logic        hs_low, vs_low;
        logic [11:0] color, exp_c;
        int          hs_end;
        out_f = drv_f; out_h = drv_h; out_v = drv_v;
        drv_f = gen_f; drv_h = gen_h; drv_v = gen_v;
        hs_end = (gen_f >= short_first && gen_f <= short_last) ? HS1 - 1 : HS1;
        hs_low = (gen_h >= HS0) && (gen_h <= hs_end);
        if (gen_f == drop_f && gen_v == drop_v) hs_low = 1'b0;
        vs_low = (gen_v >= VS0) && (gen_v <= VS1);
        color  = (gen_f == ovr_f && gen_h == ovr_h && gen_v == ovr_v) ? ovr_rgb : 12'hF00;
        hsync  = !hs_low;
        vsync  = !vs_low;
        {red, green, blue} = color;
        rst    = (gen_f == rst_f && gen_h == rst_h && gen_v == rst_v);
        @(posedge vgaclk);
        #1;
        if (exp_q.size() > 0) begin
            exp_c = exp_q.pop_front();
            if (de && rgb_o !== exp_c) bad_rgb++;
        end
        if (!de && rgb_o !== 12'h000) bad_rgb++;
        exp_q.push_back(color);
        if (out_f < NF) begin
            if (de) de_f[out_f]++;
            if (sync_err) se_f[out_f]++;
            if (locked) lk_f[out_f]++;
`ifdef VGA_RX_CRC_EN
            if (crc_valid) begin
                cv_f[out_f]++;
                crc_f[out_f] = crc16;
            end
`endif
        end
        gen_h++;
        if (gen_h == HT) begin
            gen_h = 0;
            gen_v++;
            if (gen_v == VT) begin
                gen_v = 0;
                gen_f++;
            end
        end
    endtask

    // Runs the raster until the outputs describe pixel (f, h, v).
    task automatic show(input int f, input int h, input int v);
        int  n;
        bit  hit;
        n   = 0;
        hit = 0;
        while (!hit && n < SHOW_LIMIT) begin
            drive_px();
            n++;
            hit = (out_f == f && out_h == h && out_v == v);
        end
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL show_timeout: observed=%0d/%0d/%0d expected=%0d/%0d/%0d", out_f, out_h, out_v, f, h, v);
        end
    endtask

    function automatic logic [15:0] crc_model(input bit flip);
        logic [15:0] c;
        logic [11:0] d;
        logic        fb;
        c = 16'hFFFF;
        for (int v = 0; v < VA; v++) begin
            for (int h = 0; h < HA; h++) begin
                d = (flip && h == 3 && v == 2) ? 12'h00F : 12'hF00;
                for (int b = 11; b >= 0; b--) begin
                    fb = c[15] ^ d[b];
                    c  = {c[14:0], 1'b0};
                    if (fb) c = c ^ 16'h1021;
                end
            end
        end
        return c;
    endfunction

    initial begin
        rst = 1'b1; hsync = 1'b1; vsync = 1'b1;
        red = '0; green = '0; blue = '0;
        repeat (2) @(posedge vgaclk);
        #1;
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_de", int'(de), 0);
        chk("rst_rgb", int'(rgb_o), 0);
        chk("rst_fs", int'(frame_start), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_sync_err", int'(sync_err), 0);

        // first lock: vsync fall in frame 0, wraps at end of frames 0 and 1
        show(1, 23, 12); chk("lock_before", int'(locked), 0);
        show(1, 24, 12); chk("lock_rise", int'(locked), 1);
        show(2, 0, 0);
        chk("fs_pulse", int'(frame_start), 1);
        chk("fs_de", int'(de), 1);
        chk("fs_x", int'(x), 0);
        chk("fs_y", int'(y), 0);
        chk("fs_rgb", int'(rgb_o), 'hF00);
        show(2, 1, 0); chk("fs_single", int'(frame_start), 0);
        show(2, 5, 3);
        chk("pix_x", int'(x), 5);
        chk("pix_y", int'(y), 3);
        show(2, 15, 7); chk("de_last_col", int'(de), 1);
        show(2, 16, 7);
        chk("de_first_blank", int'(de), 0);
        chk("rgb_blank", int'(rgb_o), 0);
        show(2, 20, 10);
        chk("vblank_de", int'(de), 0);
        chk("vblank_x", int'(x), 20);
        chk("vblank_y", int'(y), 10);

        // one green pixel at (5,7)
        show(3, 5, 7);
        chk("green_rgb", int'(rgb_o), 'h0F0);
        chk("green_x", int'(x), 5);
        chk("green_y", int'(y), 7);
        chk("green_de", int'(de), 1);
        show(3, 6, 7); chk("after_green_rgb", int'(rgb_o), 'hF00);
        show(3, 24, 12);
        chk("de_cnt_f1", de_f[1], 0);
        chk("de_cnt_f2", de_f[2], HA * VA);
        chk("de_cnt_f3", de_f[3], HA * VA);
        chk("se_clean_f0_3", se_f[0] + se_f[1] + se_f[2] + se_f[3], 0);

        // dropped hsync on line 3 of frame 4
        show(4, 17, 3);
        chk("drop_pre_locked", int'(locked), 1);
        chk("drop_pre_se", int'(sync_err), 0);
        show(4, 18, 3);
        chk("drop_se", int'(sync_err), 1);
        chk("drop_locked", int'(locked), 0);
        show(4, 19, 3); chk("drop_se_pulse", int'(sync_err), 0);
        show(5, 23, 12); chk("relock_before", int'(locked), 0);
        show(5, 24, 12); chk("relock_rise", int'(locked), 1);
        chk("drop_se_total", se_f[4] + se_f[5], 1);

        // one-cycle reset mid-frame while locked
        show(6, 8, 4); chk("prerst_locked", int'(locked), 1);
        show(6, 9, 4);
        chk("mrst_x", int'(x), 0);
        chk("mrst_y", int'(y), 0);
        chk("mrst_de", int'(de), 0);
        chk("mrst_rgb", int'(rgb_o), 0);
        chk("mrst_fs", int'(frame_start), 0);
        chk("mrst_locked", int'(locked), 0);
        chk("mrst_sync_err", int'(sync_err), 0);
        show(7, 23, 12); chk("rstlock_before", int'(locked), 0);
        show(7, 24, 12); chk("rstlock_rise", int'(locked), 1);
        chk("rst_se_total", se_f[6] + se_f[7], 0);

        // hsync one pixel short in frames 8..10
        show(10, 24, 12);
        chk("short_se_f8", se_f[8], 2);
        chk("short_se_f9", se_f[9], 1);
        chk("short_se_f10", se_f[10], 1);
        chk("short_lk_f9", lk_f[9], 0);
        chk("short_lk_f10", lk_f[10], 0);

`ifdef VGA_RX_CRC_EN
        ovr_f = 16; ovr_h = 3; ovr_v = 2; ovr_rgb = 12'h00F;
        show(16, 24, 12);
        chk("crc_none_f12", cv_f[12], 0);
        chk("crc_once_f13", cv_f[13], 1);
        chk("crc_once_f14", cv_f[14], 1);
        chk("crc_once_f15", cv_f[15], 1);
        chk("crc_once_f16", cv_f[16], 1);
        chk("crc_val_f13", int'(crc_f[13]), int'(crc_model(1'b0)));
        chk("crc_val_f14", int'(crc_f[14]), int'(crc_model(1'b0)));
        chk("crc_val_f15", int'(crc_f[15]), int'(crc_model(1'b0)));
        chk("crc_val_f16", int'(crc_f[16]), int'(crc_model(1'b1)));
        chk("crc_differs", int'(crc_f[16] != crc_f[15]), 1);
`endif

        chk("rgb_whenever_de", bad_rgb, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
